// File: rtl/ia_addr_sequencer_if.sv
// Scheduler handshake and address-datapath bus for ia_addr_sequencer.
// The abort input exists only when IA_SEQ_ABORT_EN is defined.
interface ia_addr_sequencer_if #(
  parameter int ram_address_width = 5
);
  logic                         start;
  logic [ram_address_width-1:0] last_addr;
  logic                         out_ready;
  logic                         busy;
  logic                         done;
  logic                         addr_bram_enable;
  logic [ram_address_width-1:0] ram_address;
  logic [2:0]                   arbiter_ctrl;
  logic                         addr_valid;
`ifdef IA_SEQ_ABORT_EN
  logic                         abort;

  modport master (
    input  start, last_addr, out_ready, abort,
    output busy, done, addr_bram_enable, ram_address, arbiter_ctrl, addr_valid
  );
  modport slave (
    output start, last_addr, out_ready, abort,
    input  busy, done, addr_bram_enable, ram_address, arbiter_ctrl, addr_valid
  );
`else
  modport master (
    input  start, last_addr, out_ready,
    output busy, done, addr_bram_enable, ram_address, arbiter_ctrl, addr_valid
  );
  modport slave (
    output start, last_addr, out_ready,
    input  busy, done, addr_bram_enable, ram_address, arbiter_ctrl, addr_valid
  );
`endif
endinterface

// File: rtl/ia_addr_sequencer.sv
// Walks the row/col address BRAMs and steps the arbiters through 4 phases per entry.
// Optional feature macro: IA_SEQ_ABORT_EN (adds bus.abort, forcing an early done).
module ia_addr_sequencer #(
  parameter int ram_address_width = 5,
  parameter int ram_depth         = 32,
  parameter int bram_latency      = 1,
  parameter int num_phases        = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  ia_addr_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_DONE
  } state_e;

  localparam logic [ram_address_width-1:0] MAX_ADDR   = ram_address_width'(ram_depth - 1);
  localparam logic [1:0]                   LAST_PHASE = 2'(num_phases - 1);
  localparam int                           WAIT_INIT_I = (bram_latency > 1) ? bram_latency - 2 : 0;
  localparam logic [1:0]                   WAIT_INIT  = 2'(WAIT_INIT_I);

  state_e                       state_q, state_d;
  logic [ram_address_width-1:0] addr_q, addr_d;
  logic [ram_address_width-1:0] last_q, last_d;
  logic [1:0]                   phase_q, phase_d;
  logic [1:0]                   wait_q, wait_d;
  logic                         abort_hit;

  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         en_q, en_d;
  logic [ram_address_width-1:0] ram_address_q, ram_address_d;
  logic [2:0]                   arb_q, arb_d;
  logic                         valid_q, valid_d;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    last_d    = last_q;
    phase_d   = phase_q;
    wait_d    = wait_q;
    abort_hit = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          last_d  = (bus.last_addr > MAX_ADDR) ? MAX_ADDR : bus.last_addr;
          addr_d  = '0;
          phase_d = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bram_latency > 1) begin
          wait_d  = WAIT_INIT;
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (wait_q == 2'd0) state_d = S_ISSUE;
        else                wait_d  = wait_q - 2'd1;
      end
      S_ISSUE: begin
        if (bus.out_ready) begin
          if (phase_q == LAST_PHASE) begin
            phase_d = '0;
            if (addr_q == last_q) begin
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = S_FETCH;
            end
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef IA_SEQ_ABORT_EN
    // Abort outranks start and out_ready; the done pulse is raised beside IDLE.
    if (bus.abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      addr_d    = '0;
      phase_d   = '0;
      wait_d    = '0;
      abort_hit = 1'b1;
    end
`endif
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    busy_d        = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_ISSUE);
    done_d        = (state_d == S_DONE) || abort_hit;
    en_d          = (state_d == S_FETCH);
    ram_address_d = (state_d == S_FETCH) ? addr_d : ram_address_q;
    valid_d       = (state_d == S_ISSUE);
    arb_d         = (state_d == S_ISSUE) ? ({1'b0, phase_d} + 3'd1) : 3'd0;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: every flop here is control state, so all are reset; there is no storage array.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      last_q        <= '0;
      phase_q       <= '0;
      wait_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      en_q          <= 1'b0;
      ram_address_q <= '0;
      arb_q         <= '0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      last_q        <= last_d;
      phase_q       <= phase_d;
      wait_q        <= wait_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      en_q          <= en_d;
      ram_address_q <= ram_address_d;
      arb_q         <= arb_d;
      valid_q       <= valid_d;
    end
  end

  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.addr_bram_enable = en_q;
  assign bus.ram_address      = ram_address_q;
  assign bus.arbiter_ctrl     = arb_q;
  assign bus.addr_valid       = valid_q;

endmodule

// File: tb/tb_ia_addr_sequencer.sv
// Directed bench for ia_addr_sequencer: one instance at bram_latency=1 (5-bit address),
// one at bram_latency=3 with a 6-bit address so an out-of-range last_addr can be driven.
module tb_ia_addr_sequencer;

  logic clock = 1'b0;
  logic rst1_n;
  logic rst3_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  ia_addr_sequencer_if #(.ram_address_width(5)) if1 ();
  ia_addr_sequencer_if #(.ram_address_width(6)) if3 ();

  ia_addr_sequencer #(
    .ram_address_width(5), .ram_depth(32), .bram_latency(1), .num_phases(4)
  ) u_l1 (
    .clock (clock),
    .reset (rst1_n),
    .bus   (if1.master)
  );

  ia_addr_sequencer #(
    .ram_address_width(6), .ram_depth(32), .bram_latency(3), .num_phases(4)
  ) u_l3 (
    .clock (clock),
    .reset (rst3_n),
    .bus   (if3.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packing: [12] busy [11] done [10] enable [9] valid [8:6] arbiter_ctrl [5:0] ram_address
  function automatic logic [12:0] vec(input int b, input int d, input int e, input int v,
                                      input int arb, input int addr);
    return {1'(b), 1'(d), 1'(e), 1'(v), 3'(arb), 6'(addr)};
  endfunction

  function automatic logic [12:0] obs(input bit use3);
    if (use3)
      return {if3.busy, if3.done, if3.addr_bram_enable, if3.addr_valid,
              if3.arbiter_ctrl, if3.ram_address};
    return {if1.busy, if1.done, if1.addr_bram_enable, if1.addr_valid,
            if1.arbiter_ctrl, 1'b0, if1.ram_address};
  endfunction

  task automatic drive_start(input bit use3, input bit v, input int last);
    if (use3) begin
      if3.start     = v;
      if3.last_addr = 6'(last);
    end else begin
      if1.start     = v;
      if1.last_addr = 5'(last);
    end
  endtask

  // Pulse start for one cycle; returns on the negedge of the first FETCH cycle.
  task automatic kick(input bit use3, input int last);
    drive_start(use3, 1'b1, last);
    @(negedge clock);
    drive_start(use3, 1'b0, last);
  endtask

  // Checks every cycle of a sweep with out_ready high against the FETCH/WAIT/ISSUE pattern.
  task automatic run_sweep(input string name, input bit use3, input int last_eff,
                           input int restart_at, input int stop_at);
    int per, nw, total, fetches, e, p;
    logic [12:0] ex, got;
    per     = use3 ? 7 : 5;
    nw      = use3 ? 2 : 0;
    total   = (last_eff + 1) * per;
    fetches = 0;
    for (int c = 0; c <= total + 1; c++) begin
      e = c / per;
      p = c % per;
      if (c < total) begin
        if (p == 0)       ex = vec(1, 0, 1, 0, 0, e);
        else if (p <= nw) ex = vec(1, 0, 0, 0, 0, e);
        else              ex = vec(1, 0, 0, 1, p - nw, e);
      end else if (c == total) begin
        ex = vec(0, 1, 0, 0, 0, last_eff);
      end else begin
        ex = vec(0, 0, 0, 0, 0, last_eff);
      end
      got = obs(use3);
      if (got[10]) fetches++;
      check($sformatf("%s c%0d", name, c), 32'(got), 32'(ex));
      if (c == stop_at) return;
      if (c == restart_at)     drive_start(use3, 1'b1, 3);
      if (c == restart_at + 1) drive_start(use3, 1'b0, 3);
      @(negedge clock);
    end
    check({name, " fetch count"}, 32'(fetches), 32'(last_eff + 1));
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bp_arb[10];
    int fetches;
    logic [12:0] ex, got;
    bp_arb = '{0, 1, 2, 2, 2, 2, 3, 4, 0, 0};

    rst1_n = 1'b0;
    rst3_n = 1'b0;
    if1.start = 1'b0; if1.last_addr = '0; if1.out_ready = 1'b1;
    if3.start = 1'b0; if3.last_addr = '0; if3.out_ready = 1'b1;
`ifdef IA_SEQ_ABORT_EN
    if1.abort = 1'b0;
    if3.abort = 1'b0;
`endif
    repeat (2) @(negedge clock);
    check("reset l1", 32'(obs(1'b0)), 32'(0));
    check("reset l3", 32'(obs(1'b1)), 32'(0));
    rst1_n = 1'b1;
    rst3_n = 1'b1;
    @(negedge clock);

    // Full sweep at latency 1: done 160 cycles after busy rises.
    kick(1'b0, 31);
    run_sweep("full", 1'b0, 31, -1, -1);

    // Backpressure on phase 2 with a single entry.
    kick(1'b0, 0);
    fetches = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 0)      ex = vec(1, 0, 1, 0, 0, 0);
      else if (c < 8)  ex = vec(1, 0, 0, 1, bp_arb[c], 0);
      else if (c == 8) ex = vec(0, 1, 0, 0, 0, 0);
      else             ex = vec(0, 0, 0, 0, 0, 0);
      got = obs(1'b0);
      if (got[10]) fetches++;
      check($sformatf("bp c%0d", c), 32'(got), 32'(ex));
      if (c == 2) if1.out_ready = 1'b0;
      if (c == 5) if1.out_ready = 1'b1;
      @(negedge clock);
    end
    check("bp fetch count", 32'(fetches), 32'(1));

    // Latency 3: FETCH, 2 WAIT, 4 ISSUE per entry.
    kick(1'b1, 1);
    run_sweep("lat3", 1'b1, 1, -1, -1);

    // Clamp 40 -> 31, with a start pulse mid-sweep that must be ignored.
    kick(1'b1, 40);
    run_sweep("clamp", 1'b1, 31, 50, -1);

    // Reset at address 5, phase 3.
    kick(1'b0, 31);
    run_sweep("pre_rst", 1'b0, 31, -1, 28);
    rst1_n = 1'b0;
    #1;
    check("rst async outputs", 32'(obs(1'b0)), 32'(0));
    @(negedge clock);
    check("rst no done 1", 32'(if1.done), 32'(0));
    @(negedge clock);
    check("rst no done 2", 32'(obs(1'b0)), 32'(0));
    rst1_n = 1'b1;
    @(negedge clock);
    kick(1'b0, 2);
    run_sweep("post_rst", 1'b0, 2, -1, -1);

`ifdef IA_SEQ_ABORT_EN
    // Abort during ISSUE at address 7 (cycle 36 carries phase 1).
    kick(1'b0, 31);
    run_sweep("pre_abort", 1'b0, 31, -1, 36);
    if1.abort = 1'b1;
    @(negedge clock);
    if1.abort = 1'b0;
    check("abort pulse", 32'({if1.done, if1.busy, if1.addr_valid, if1.arbiter_ctrl}),
          32'(6'b10_0_000));
    @(negedge clock);
    check("abort idle", 32'({if1.done, if1.busy, if1.addr_bram_enable, if1.addr_valid,
                             if1.arbiter_ctrl}), 32'(0));
    kick(1'b0, 0);
    run_sweep("post_abort", 1'b0, 0, -1, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
